// File: rtl/cp0_vec_pkg.sv
// -----------------------------------------------------------------------------
// cp0_vec_pkg
//   Shared definitions for the vectored coprocessor-0:
//   - CP0 register addresses (COUNT, COMPARE, STATUS, CAUSE, EPC, EHBR)
//   - STATUS / CAUSE field positions
//   - EXE-stage CP0 operation encodings
// -----------------------------------------------------------------------------
package cp0_vec_pkg;

   // Register addresses
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_EHBR    = 5'd15;

   // STATUS fields
   localparam int STATUS_IE_BIT  = 0;
   localparam int STATUS_EXL_BIT = 1;
   localparam int STATUS_IM_LSB  = 8;

   // CAUSE fields
   localparam int CAUSE_CODE_LSB = 2;
   localparam int CAUSE_CODE_W   = 5;
   localparam int CAUSE_IP_LSB   = 8;

   // CP0 operation issued from EXE
   typedef enum logic [1:0] {
      EXE_CP_NONE  = 2'd0,
      EXE_CP_STORE = 2'd1,
      EXE_CP0_ERET = 2'd2
   } cp0_oper_e;

endpackage

// File: rtl/cp0_vec_if.sv
// -----------------------------------------------------------------------------
// cp0_vec_if
//   Pipeline <-> CP0 bus.
//   master (pipeline): drives oper, addr_r, addr_w, data_w, ir_en, ir_in,
//                      ret_addr; receives data_r, jump_en, jump_addr, exl.
//   slave  (cp0_vec) : the mirror image.
// -----------------------------------------------------------------------------
interface cp0_vec_if #(
   parameter int NUM_IRQ = 6,
   parameter int DATA_W  = 32
);
   import cp0_vec_pkg::*;

   cp0_oper_e           oper;      // EXE-stage CP0 operation
   logic [4:0]          addr_r;    // ID-stage read address
   logic [DATA_W-1:0]   data_r;    // read data, combinational from addr_r
   logic [4:0]          addr_w;    // EXE-stage write address
   logic [DATA_W-1:0]   data_w;    // EXE-stage write data
   logic                ir_en;     // pipeline can accept an interrupt now
   logic [NUM_IRQ-1:0]  ir_in;     // external level requests
   logic [DATA_W-1:0]   ret_addr;  // PC saved into EPC on interrupt take
   logic                jump_en;   // redirect fetch
   logic [DATA_W-1:0]   jump_addr; // redirect target
   logic                exl;       // handler active

   modport master (
      output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
      input  data_r, jump_en, jump_addr, exl
   );

   modport slave (
      input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
      output data_r, jump_en, jump_addr, exl
   );

endinterface

// File: rtl/cp0_irq_arb.sv
// -----------------------------------------------------------------------------
// cp0_irq_arb
//   Purely combinational lowest-index-first priority encoder over the
//   masked pending vector.
//   pending, mask : N request / enable bits
//   any           : at least one request is pending and enabled
//   idx           : index of the winning request (0 when any == 0)
// -----------------------------------------------------------------------------
module cp0_irq_arb #(
   parameter int N = 7
) (
   input  logic [N-1:0] pending,
   input  logic [N-1:0] mask,
   output logic         any,
   output logic [4:0]   idx
);

   logic [N-1:0] req;

   assign req = pending & mask;
   assign any = |req;

   // NOTE: idx gets a default before the loop so every path assigns it and
   //       no latch is inferred.
   always_comb begin
      idx = '0;
      // Walk downwards so the last hit, the lowest index, wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = 5'(i);
      end
   end

endmodule

// File: rtl/cp0_vec.sv
// -----------------------------------------------------------------------------
// cp0_vec
//   Coprocessor-0 with NUM_IRQ masked external interrupt lines plus a
//   COUNT/COMPARE timer line (index NUM_IRQ, lowest priority), vectored
//   handler entry at EHBR + (idx << VEC_SHIFT), EXL re-entry lock and ERET.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cp0_vec_if.slave (reads in ID, writes/ERET in EXE, take in MEM)
// -----------------------------------------------------------------------------
module cp0_vec
   import cp0_vec_pkg::*;
#(
   parameter int NUM_IRQ   = 6,
   parameter int VEC_SHIFT = 5,
   parameter int DATA_W    = 32
) (
   input  logic     clk,
   input  logic     rst,
   cp0_vec_if.slave bus
);

   localparam int NP = NUM_IRQ + 1;   // external lines plus timer

   logic [DATA_W-1:0] count_q,   count_d;
   logic [DATA_W-1:0] compare_q, compare_d;
   logic [DATA_W-1:0] epc_q,     epc_d;
   logic [DATA_W-1:0] ehbr_q,    ehbr_d;
   logic              ie_q,      ie_d;
   logic              exl_q,     exl_d;
   logic [NP-1:0]     im_q,      im_d;
   logic [NP-1:0]     pend_q,    pend_d;
   logic [4:0]        code_q,    code_d;

   logic              arb_any;
   logic [4:0]        arb_idx;
   logic              ir;
   logic              store_en;
   logic              eret_en;
   logic [DATA_W-1:0] vec_addr;

   cp0_irq_arb #(.N(NP)) u_arb (
      .pending (pend_q),
      .mask    (im_q),
      .any     (arb_any),
      .idx     (arb_idx)
   );

   // Interrupt take outranks ERET and STORE; those two are exclusive by
   // encoding, so a STORE can never coincide with an ERET.
   assign ir       = bus.ir_en & ie_q & ~exl_q & arb_any;
   assign store_en = (bus.oper == EXE_CP_STORE) & ~ir;
   assign eret_en  = (bus.oper == EXE_CP0_ERET) & ~ir;
   assign vec_addr = ehbr_q + (DATA_W'(arb_idx) << VEC_SHIFT);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      count_d   = count_q + 1'b1;   // wraps naturally at 2^DATA_W
      compare_d = compare_q;
      epc_d     = epc_q;
      ehbr_d    = ehbr_q;
      ie_d      = ie_q;
      exl_d     = exl_q;
      im_d      = im_q;
      code_d    = code_q;
      pend_d    = pend_q;

      // External lines: W1C clear first, then a same-cycle request re-sets.
      if (store_en && bus.addr_w == CP0_CAUSE) begin
         pend_d[NUM_IRQ-1:0] = pend_q[NUM_IRQ-1:0] & ~bus.data_w[CAUSE_IP_LSB +: NUM_IRQ];
      end
      pend_d[NUM_IRQ-1:0] = pend_d[NUM_IRQ-1:0] | bus.ir_in;

      // Timer line: set on match, then a COMPARE write clears (clear wins).
      if (count_q == compare_q) pend_d[NUM_IRQ] = 1'b1;
      if (store_en && bus.addr_w == CP0_COMPARE) pend_d[NUM_IRQ] = 1'b0;

      if (store_en) begin
         unique case (bus.addr_w)
            CP0_COUNT:   count_d   = bus.data_w;
            CP0_COMPARE: compare_d = bus.data_w;
            CP0_STATUS: begin
               ie_d  = bus.data_w[STATUS_IE_BIT];
               exl_d = bus.data_w[STATUS_EXL_BIT];
               im_d  = bus.data_w[STATUS_IM_LSB +: NP];
            end
            CP0_EPC:     epc_d     = bus.data_w;
            CP0_EHBR:    ehbr_d    = bus.data_w;
            default: ;   // CAUSE handled above; other addresses ignored
         endcase
      end

      if (eret_en) exl_d = 1'b0;

      // The pending bit stays set; the handler clears it through CAUSE.
      if (ir) begin
         epc_d  = bus.ret_addr;
         exl_d  = 1'b1;
         code_d = arb_idx;
      end
   end

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   // NOTE: state updates use non-blocking assignments so every flop samples
   //       the pre-edge value of every other flop, independent of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         compare_q <= '0;
         epc_q     <= '0;
         ehbr_q    <= '0;
         ie_q      <= 1'b0;
         exl_q     <= 1'b0;
         im_q      <= '0;
         pend_q    <= '0;
         code_q    <= '0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         epc_q     <= epc_d;
         ehbr_q    <= ehbr_d;
         ie_q      <= ie_d;
         exl_q     <= exl_d;
         im_q      <= im_d;
         pend_q    <= pend_d;
         code_q    <= code_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      bus.jump_en   = ~rst & (ir | eret_en);
      bus.jump_addr = '0;
      if (bus.jump_en) bus.jump_addr = ir ? vec_addr : epc_q;
   end

   assign bus.exl = exl_q;

   always_comb begin
      bus.data_r = '0;
      unique case (bus.addr_r)
         CP0_COUNT:   bus.data_r = count_q;
         CP0_COMPARE: bus.data_r = compare_q;
         CP0_STATUS: begin
            bus.data_r[STATUS_IE_BIT]          = ie_q;
            bus.data_r[STATUS_EXL_BIT]         = exl_q;
            bus.data_r[STATUS_IM_LSB +: NP]    = im_q;
         end
         CP0_CAUSE: begin
            bus.data_r[CAUSE_IP_LSB +: NP]             = pend_q;
            bus.data_r[CAUSE_CODE_LSB +: CAUSE_CODE_W] = code_q;
         end
         CP0_EPC:     bus.data_r = epc_q;
         CP0_EHBR:    bus.data_r = ehbr_q;
         default: ;
      endcase
   end

endmodule
